// File: rtl/pulse_meter_if.sv
// Bundles the start/signal inputs, timeout limit and measurement results of pulse_meter.
// Purely combinational wiring; no latency of its own.
// No backpressure: inputs are sampled every cycle and results are simply held.
interface pulse_meter_if;
  logic        i_START;
  logic        i_SIGNAL;
  logic [31:0] i_TIMEOUT;
  logic        o_BUSY;
  logic        o_DONE;
  logic        o_TIMEOUT;
  logic [31:0] o_DELAY;
  logic [31:0] o_WIDTH;

  modport master (
    output i_START, i_SIGNAL, i_TIMEOUT,
    input  o_BUSY, o_DONE, o_TIMEOUT, o_DELAY, o_WIDTH
  );

  modport slave (
    input  i_START, i_SIGNAL, i_TIMEOUT,
    output o_BUSY, o_DONE, o_TIMEOUT, o_DELAY, o_WIDTH
  );
endinterface

// File: rtl/pulse_meter.sv
// Measures cycles from a start rising edge to a signal rising edge, and the signal's high width.
// Results and o_DONE appear one cycle after the completing (fall) or aborting (timeout) edge.
// No backpressure: start edges arriving while busy are dropped, nothing is queued.
module pulse_meter #(
  parameter logic INIT_START_STATE = 1'b0,
  parameter logic INIT_SIG_STATE   = 1'b0
) (
  input logic          i_CLK,
  input logic          i_RST_N,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    s_IDLE = 2'b00,
    s_WAIT = 2'b01,
    s_HIGH = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        start_q;
  logic        sig_q;
  logic [31:0] dcnt;
  logic [31:0] wcnt;
  logic [31:0] tcnt;
  logic [31:0] timeout_r;
  logic [31:0] delay_r;

  logic        busy_r;
  logic        done_r;
  logic        to_r;
  logic [31:0] delay_o;
  logic [31:0] width_o;

  logic        arm;
  logic        capture;
  logic        complete;
  logic        abort_wait;
  logic        abort_high;
  logic        dcnt_inc;
  logic        wcnt_inc;
  logic        tcnt_inc;

  wire start_rise = bus.i_START & ~start_q;
  wire sig_rise   = bus.i_SIGNAL & ~sig_q;
  // A zero limit disables the abort entirely.
  wire to_hit     = (timeout_r != 32'd0) && (tcnt >= timeout_r);

  // Counters stick at all-ones so a very long wait never looks short.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // State register.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) state <= s_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control; a signal event beats the timeout on the same edge.
  always_comb begin
    state_nxt  = s_IDLE;
    arm        = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    abort_wait = 1'b0;
    abort_high = 1'b0;
    dcnt_inc   = 1'b0;
    wcnt_inc   = 1'b0;
    tcnt_inc   = 1'b0;
    case (state)
      s_IDLE: begin
        if (start_rise) begin
          arm       = 1'b1;
          state_nxt = s_WAIT;
        end
      end
      s_WAIT: begin
        tcnt_inc  = 1'b1;
        state_nxt = s_WAIT;
        if (sig_rise) begin
          capture   = 1'b1;
          state_nxt = s_HIGH;
        end else if (to_hit) begin
          abort_wait = 1'b1;
          state_nxt  = s_IDLE;
        end else begin
          dcnt_inc = 1'b1;
        end
      end
      s_HIGH: begin
        tcnt_inc  = 1'b1;
        state_nxt = s_HIGH;
        if (!bus.i_SIGNAL) begin
          complete  = 1'b1;
          state_nxt = s_IDLE;
        end else if (to_hit) begin
          abort_high = 1'b1;
          state_nxt  = s_IDLE;
        end else begin
          wcnt_inc = 1'b1;
        end
      end
      default: state_nxt = s_IDLE;
    endcase
  end

  // Edge samplers and measurement counters.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      start_q   <= INIT_START_STATE;
      sig_q     <= INIT_SIG_STATE;
      dcnt      <= 32'd0;
      wcnt      <= 32'd0;
      tcnt      <= 32'd0;
      timeout_r <= 32'd0;
      delay_r   <= 32'd0;
    end else begin
      start_q <= bus.i_START;
      sig_q   <= bus.i_SIGNAL;
      if (arm) begin
        dcnt      <= 32'd0;
        tcnt      <= 32'd1;
        timeout_r <= bus.i_TIMEOUT;
      end
      if (tcnt_inc) tcnt <= sat_inc(tcnt);
      if (dcnt_inc) dcnt <= sat_inc(dcnt);
      if (capture) begin
        delay_r <= dcnt;
        wcnt    <= 32'd1;
      end
      if (wcnt_inc) wcnt <= sat_inc(wcnt);
    end
  end

  // Registered status and results, updated together on the finishing edge.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      to_r    <= 1'b0;
      delay_o <= 32'd0;
      width_o <= 32'd0;
    end else begin
      busy_r <= (state_nxt != s_IDLE);
      done_r <= complete | abort_wait | abort_high;
      if (complete) begin
        delay_o <= delay_r;
        width_o <= wcnt;
        to_r    <= 1'b0;
      end
      if (abort_wait) begin
        delay_o <= 32'hFFFF_FFFF;
        width_o <= 32'd0;
        to_r    <= 1'b1;
      end
      if (abort_high) begin
        delay_o <= delay_r;
        width_o <= 32'hFFFF_FFFF;
        to_r    <= 1'b1;
      end
    end
  end

  assign bus.o_BUSY    = busy_r;
  assign bus.o_DONE    = done_r;
  assign bus.o_TIMEOUT = to_r;
  assign bus.o_DELAY   = delay_o;
  assign bus.o_WIDTH   = width_o;

endmodule

// File: tb/tb_pulse_meter.sv
// Drives per-edge start/signal/reset/timeout tables into pulse_meter and checks every cycle.
// Expected outputs come from an index-scanning model of measurements over the whole table.
// No backpressure involved; each table edge is applied and checked once.
module tb_pulse_meter;

  localparam int MAXL = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done;
  int   last_done;

  pulse_meter_if bus();

  pulse_meter #(
    .INIT_START_STATE(1'b0),
    .INIT_SIG_STATE  (1'b0)
  ) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Stimulus tables: value applied at edge k; rs[k]=1 means reset asserted at edge k.
  logic        st[MAXL];
  logic        sg[MAXL];
  logic        rs[MAXL];
  logic [31:0] tm[MAXL];
  // Expected outputs just after edge k.
  logic        ebusy[MAXL];
  logic        edone[MAXL];
  logic        eto[MAXL];
  logic [31:0] edly[MAXL];
  logic [31:0] ewid[MAXL];

  function automatic logic prev_st(input int k);
    return (k == 0 || rs[k-1]) ? 1'b0 : st[k-1];
  endfunction

  function automatic logic prev_sg(input int k);
    return (k == 0 || rs[k-1]) ? 1'b0 : sg[k-1];
  endfunction

  task automatic put(input int k, input logic b, input logic dn,
                     input logic [31:0] d, input logic [31:0] w, input logic t);
    ebusy[k] = b; edone[k] = dn; edly[k] = d; ewid[k] = w; eto[k] = t;
  endtask

  // Each measurement: t0 = start rise; t1 = first signal rise after t0; t2 = first low after t1.
  // delay = t1-t0-1, width = t2-t1; abort at edge t0+limit unless an event lands on that edge.
  task automatic model(input int len);
    logic [31:0] d = 32'd0;
    logic [31:0] w = 32'd0;
    logic        to = 1'b0;
    int          k = 0;
    while (k < len) begin
      if (rs[k]) begin
        d = 32'd0; w = 32'd0; to = 1'b0;
        put(k, 1'b0, 1'b0, d, w, to);
        k++;
      end else if (!(st[k] && !prev_st(k))) begin
        put(k, 1'b0, 1'b0, d, w, to);
        k++;
      end else begin
        int          t0 = k;
        int          lim = int'(tm[k]);
        int          e = -1;
        int          t1 = -1;
        int          j;
        logic [31:0] nd = 32'd0;
        logic [31:0] nw = 32'd0;
        logic        nto = 1'b0;
        for (j = t0 + 1; j < len; j++) begin
          if (rs[j]) break;
          if (sg[j] && !prev_sg(j)) begin t1 = j; break; end
          if (lim != 0 && j - t0 >= lim) begin
            e = j; nd = 32'hFFFF_FFFF; nw = 32'd0; nto = 1'b1; break;
          end
        end
        if (t1 >= 0) begin
          for (j = t1 + 1; j < len; j++) begin
            if (rs[j]) break;
            if (!sg[j]) begin
              e = j; nd = 32'(t1 - t0 - 1); nw = 32'(j - t1); nto = 1'b0; break;
            end
            if (lim != 0 && j - t0 >= lim) begin
              e = j; nd = 32'(t1 - t0 - 1); nw = 32'hFFFF_FFFF; nto = 1'b1; break;
            end
          end
        end
        for (int m = t0; m < j; m++) put(m, 1'b1, 1'b0, d, w, to);
        if (e >= 0) begin
          d = nd; w = nw; to = nto;
          put(e, 1'b0, 1'b1, d, w, to);
          k = e + 1;
        end else begin
          k = j;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int edge_i,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_i, obs, exp);
    end
  endtask

  task automatic run(input int len);
    model(len);
    n_done = 0;
    last_done = -1;
    for (int k = 0; k < len; k++) begin
      rst_n         = ~rs[k];
      bus.i_START   = st[k];
      bus.i_SIGNAL  = sg[k];
      bus.i_TIMEOUT = tm[k];
      @(posedge clk);
      #1;
      if (bus.o_DONE === 1'b1) begin n_done++; last_done = k; end
      chk("busy",    k, 32'(bus.o_BUSY),    32'(ebusy[k]));
      chk("done",    k, 32'(bus.o_DONE),    32'(edone[k]));
      chk("timeout", k, 32'(bus.o_TIMEOUT), 32'(eto[k]));
      chk("delay",   k, bus.o_DELAY,        edly[k]);
      chk("width",   k, bus.o_WIDTH,        ewid[k]);
    end
  endtask

  // Directed scenario base: reset at edge 0, start rises at edge 3 (t0=3), held two edges.
  task automatic scen(input int len, input logic [31:0] lim);
    for (int k = 0; k < MAXL; k++) begin
      st[k] = 1'b0; sg[k] = 1'b0; rs[k] = 1'b0; tm[k] = lim;
    end
    rs[0] = 1'b1;
    if (len > 4) begin st[3] = 1'b1; st[4] = 1'b1; end
  endtask

  task automatic hi(input int a, input int b);
    for (int k = a; k <= b; k++) sg[k] = 1'b1;
  endtask

  task automatic result(input string tag, input int dn, input int de,
                        input logic [31:0] d, input logic [31:0] w, input logic t);
    chk({tag, "_ndone"},   0, 32'(n_done), 32'(dn));
    chk({tag, "_doneedge"}, 0, 32'(last_done), 32'(de));
    chk({tag, "_delay"},   0, bus.o_DELAY, d);
    chk({tag, "_width"},   0, bus.o_WIDTH, w);
    chk({tag, "_tmo"},     0, 32'(bus.o_TIMEOUT), 32'(t));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_START = 1'b0;
    bus.i_SIGNAL = 1'b0;
    bus.i_TIMEOUT = 32'd0;

    // Basic capture: high at t0+6..t0+9.
    scen(20, 32'd0); hi(9, 12); run(20);
    result("basic", 1, 13, 32'd5, 32'd4, 1'b0);

    // Loopback of a delayer with DELAY=10, WIDTH=3.
    scen(24, 32'd0); hi(14, 16); run(24);
    result("loop10", 1, 17, 32'd10, 32'd3, 1'b0);

    // Loopback with DELAY=1, WIDTH=1.
    scen(12, 32'd0); hi(5, 5); run(12);
    result("loop1", 1, 6, 32'd1, 32'd1, 1'b0);

    // Timeout while waiting.
    scen(30, 32'd20); run(30);
    result("to_wait", 1, 23, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Timeout while high: rises at t0+5 and stays high.
    scen(30, 32'd20); hi(8, 29); run(30);
    result("to_high", 1, 23, 32'd4, 32'hFFFF_FFFF, 1'b1);

    // Minimum: high only at t0+1.
    scen(10, 32'd0); hi(4, 4); run(10);
    result("min", 1, 5, 32'd0, 32'd1, 1'b0);

    // Already high before t0: only the later rise counts.
    scen(16, 32'd0); hi(1, 5); hi(9, 10); run(16);
    result("prehigh", 1, 11, 32'd5, 32'd2, 1'b0);

    // Second start edge during the high phase is ignored.
    scen(18, 32'd0); hi(7, 11); st[9] = 1'b1; st[10] = 1'b1; run(18);
    result("ign_start", 1, 12, 32'd3, 32'd5, 1'b0);

    // Reset in the high phase, then a fresh 2/2 measurement.
    scen(24, 32'd0); hi(6, 11); rs[8] = 1'b1; st[13] = 1'b1; hi(16, 17); run(24);
    result("rst_mid", 1, 18, 32'd2, 32'd2, 1'b0);

    // Fall lands exactly on the timeout edge: completion wins.
    scen(14, 32'd6); hi(6, 8); run(14);
    result("prio", 1, 9, 32'd2, 32'd3, 1'b0);

    // Randomized tables, including limit changes while busy and stray resets.
    for (int s = 0; s < 25; s++) begin
      logic        lvl = 1'b0;
      logic [31:0] lim;
      scen(0, 32'd0);
      lim = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      for (int k = 0; k < 100; k++) begin
        if ($urandom_range(0, 15) == 0)
          lim = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
        tm[k] = lim;
        st[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) lvl = ~lvl;
        sg[k] = lvl;
        rs[k] = (k == 0) || ($urandom_range(0, 79) == 0);
      end
      run(100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
